dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the RISC-V core's load/store port and a host/debug loader port. It sits between the core's `wr/rd/addr/wr_data/rd_data` memory interface and the data memory macro. It grants one requester per cycle, returns read data one cycle later to the requester that issued the read, and drives a stall to the core whenever the core requests but is not granted. Round-robin on contention; the host can lock for bounded bursts.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arb_rsp.sv | 39 +++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_ADDR_W = 9;
    localparam int unsigned DMEM_DATA_W = 32;

    // Owner of the most recent grant; also tags pending read responses.
    typedef enum logic {
        LAST_CORE = 1'b0,
        LAST_HOST = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, host and memory-side signals around the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = dmem_arb_pkg::DMEM_ADDR_W,
    parameter int unsigned DATA_W = dmem_arb_pkg::DMEM_DATA_W
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;
    logic              core_stall;

    logic              h_req;
    logic              h_we;
    logic              h_lock;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_gnt;
    logic              h_rvalid;
    logic [DATA_W-1:0] h_rdata;

    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    // Requesters and memory macro side.
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata, core_stall,
        output h_req, h_we, h_lock, h_addr, h_wdata,
        input  h_gnt, h_rvalid, h_rdata,
        input  mem_wr, mem_rd, mem_addr, mem_wr_data,
        output mem_rd_data
    );

    // Arbiter side.
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata, core_stall,
        input  h_req, h_we, h_lock, h_addr, h_wdata,
        output h_gnt, h_rvalid, h_rdata,
        output mem_wr, mem_rd, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

endinterface

// File: rtl/dmem_arb_rsp.sv
// Tracks the one-cycle read response and routes memory read data to its owner.
module dmem_arb_rsp
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd_i,
    input  arb_owner_t        owner_i,
    input  logic [DATA_W-1:0] mem_rd_data_i,
    output logic              c_rvalid_o,
    output logic [DATA_W-1:0] c_rdata_o,
    output logic              h_rvalid_o,
    output logic [DATA_W-1:0] h_rdata_o
);

    logic       rsp_valid_q;
    arb_owner_t rsp_owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= LAST_CORE;
        end else begin
            rsp_valid_q <= mem_rd_i;
            rsp_owner_q <= owner_i;
        end
    end

    // Non-owner port sees zero data so stale memory output never leaks across ports.
    always_comb begin
        c_rvalid_o = rsp_valid_q && (rsp_owner_q == LAST_CORE);
        h_rvalid_o = rsp_valid_q && (rsp_owner_q == LAST_HOST);
        c_rdata_o  = c_rvalid_o ? mem_rd_data_i : '0;
        h_rdata_o  = h_rvalid_o ? mem_rd_data_i : '0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory with round-robin and bounded host lock.
// Optional core stall counter on output stall_cnt when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DMEM_DATA_W,
    parameter int unsigned ADDR_W    = DMEM_ADDR_W,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    arb_owner_t         last_q, last_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               c_gnt_c;
    logic               h_gnt_c;
    logic               lock_ok_c;
    logic [ADDR_W-1:0]  mem_addr_c;
    logic [DATA_W-1:0]  mem_wdata_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q  <= LAST_HOST;
            burst_q <= '0;
        end else begin
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    // Grant selection plus next owner and host burst accounting.
    always_comb begin
        last_d    = last_q;
        burst_d   = burst_q;
        c_gnt_c   = 1'b0;
        h_gnt_c   = 1'b0;
        lock_ok_c = bus.h_lock && (burst_q < BURST_MAX);

        if (reset) begin
            if (bus.c_req && bus.h_req) begin
                if (lock_ok_c || (last_q == LAST_CORE)) begin
                    h_gnt_c = 1'b1;
                end else begin
                    c_gnt_c = 1'b1;
                end
            end else begin
                c_gnt_c = bus.c_req;
                h_gnt_c = bus.h_req;
            end
        end

        if (c_gnt_c) begin
            last_d = LAST_CORE;
        end else if (h_gnt_c) begin
            last_d = LAST_HOST;
        end

        // Burst only counts host grants that actually kept the core waiting.
        if (!bus.c_req || c_gnt_c) begin
            burst_d = '0;
        end else if (h_gnt_c && (burst_q < BURST_MAX)) begin
            burst_d = burst_q + BURST_W'(1);
        end
    end

    always_comb begin
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (c_gnt_c) begin
            mem_addr_c  = bus.c_addr;
            mem_wdata_c = bus.c_wdata;
        end else if (h_gnt_c) begin
            mem_addr_c  = bus.h_addr;
            mem_wdata_c = bus.h_wdata;
        end
    end

    assign bus.c_gnt       = c_gnt_c;
    assign bus.h_gnt       = h_gnt_c;
    assign bus.core_stall  = bus.c_req && !c_gnt_c;
    assign bus.mem_wr      = (c_gnt_c && bus.c_we) || (h_gnt_c && bus.h_we);
    assign bus.mem_rd      = (c_gnt_c && !bus.c_we) || (h_gnt_c && !bus.h_we);
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wr_data = mem_wdata_c;

    dmem_arb_rsp #(
        .DATA_W (DATA_W)
    ) u_rsp (
        .clk           (clk),
        .reset         (reset),
        .mem_rd_i      (bus.mem_rd),
        .owner_i       (h_gnt_c ? LAST_HOST : LAST_CORE),
        .mem_rd_data_i (bus.mem_rd_data),
        .c_rvalid_o    (bus.c_rvalid),
        .c_rdata_o     (bus.c_rdata),
        .h_rvalid_o    (bus.h_rvalid),
        .h_rdata_o     (bus.h_rdata)
    );

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (bus.core_stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural memory macro.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dmem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt;
`endif

    dmem_arbiter #(
        .DATA_W    (32),
        .ADDR_W    (9),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_ARB_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        if (a == 9'h010) return 32'hDEADBEEF;
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Memory macro: read data valid one cycle after mem_rd, junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rd_data <= mem_word(bus.mem_addr);
        else            bus.mem_rd_data <= 32'hBAD0BAD0;
    end

    task automatic drive(input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
                         input logic hr, input logic hw, input logic hl, input logic [8:0] ha,
                         input logic [31:0] hd);
        bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
        bus.h_req = hr; bus.h_we = hw; bus.h_lock = hl; bus.h_addr = ha; bus.h_wdata = hd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 9'h011, 32'h0, 1'b1, 1'b0, 1'b0, 9'h022, 32'h0);
        @(negedge clk); #1;
        checks++;
        if ({bus.c_gnt, bus.h_gnt, bus.mem_rd, bus.mem_wr} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_grants: got %b expected 0000",
                     {bus.c_gnt, bus.h_gnt, bus.mem_rd, bus.mem_wr});
        end
        checks++;
        if ({bus.c_rvalid, bus.h_rvalid, bus.c_rdata, bus.h_rdata} !== 66'h0) begin
            errors++;
            $display("FAIL reset_rsp: got rvalid %b%b rdata %h/%h expected all zero",
                     bus.c_rvalid, bus.h_rvalid, bus.c_rdata, bus.h_rdata);
        end
`ifdef DMEM_ARB_PERF_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
`endif
        idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_core_read();
        @(negedge clk);
        drive(1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        #1;
        checks++;
        if ({bus.c_gnt, bus.h_gnt, bus.mem_rd, bus.mem_wr, bus.core_stall} !== 5'b10100) begin
            errors++;
            $display("FAIL core_read_gnt: got %b expected 10100",
                     {bus.c_gnt, bus.h_gnt, bus.mem_rd, bus.mem_wr, bus.core_stall});
        end
        checks++;
        if (bus.mem_addr !== 9'h010) begin
            errors++;
            $display("FAIL core_read_addr: got %h expected 010", bus.mem_addr);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({bus.c_rvalid, bus.h_rvalid} !== 2'b10 || bus.c_rdata !== 32'hDEADBEEF ||
            bus.h_rdata !== 32'h0) begin
            errors++;
            $display("FAIL core_read_rsp: got rvalid %b%b c_rdata %h h_rdata %h expected 10 deadbeef 0",
                     bus.c_rvalid, bus.h_rvalid, bus.c_rdata, bus.h_rdata);
        end
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        @(negedge clk);
        drive(1'b1, 1'b0, 9'h020, 32'h0, 1'b1, 1'b0, 1'b0, 9'h030, 32'h0);
        #1;
        checks++;
        if ({bus.c_gnt, bus.h_gnt, bus.core_stall} !== 3'b100 || bus.mem_addr !== 9'h020) begin
            errors++;
            $display("FAIL tie_first: got gnt/stall %b addr %h expected 100 020",
                     {bus.c_gnt, bus.h_gnt, bus.core_stall}, bus.mem_addr);
        end
        @(negedge clk);
        bus.c_req = 1'b0;
        #1;
        checks++;
        if ({bus.c_gnt, bus.h_gnt, bus.mem_rd} !== 3'b011 || bus.mem_addr !== 9'h030) begin
            errors++;
            $display("FAIL tie_second: got gnt/rd %b addr %h expected 011 030",
                     {bus.c_gnt, bus.h_gnt, bus.mem_rd}, bus.mem_addr);
        end
        checks++;
        if ({bus.c_rvalid, bus.h_rvalid} !== 2'b10 || bus.c_rdata !== 32'hA500_0020) begin
            errors++;
            $display("FAIL tie_core_rsp: got rvalid %b%b c_rdata %h expected 10 a5000020",
                     bus.c_rvalid, bus.h_rvalid, bus.c_rdata);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({bus.c_rvalid, bus.h_rvalid} !== 2'b01 || bus.h_rdata !== 32'hA500_0030 ||
            bus.c_rdata !== 32'h0) begin
            errors++;
            $display("FAIL tie_host_rsp: got rvalid %b%b h_rdata %h c_rdata %h expected 01 a5000030 0",
                     bus.c_rvalid, bus.h_rvalid, bus.h_rdata, bus.c_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic exp_c;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 9'(9'h040 + i), 32'h0, 1'b1, 1'b0, 1'b0, 9'(9'h080 + i), 32'h0);
            #1;
            exp_c = (i % 2 == 0);
            checks++;
            if ({bus.c_gnt, bus.h_gnt, bus.core_stall} !== {exp_c, !exp_c, !exp_c}) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b expected %b", i,
                         {bus.c_gnt, bus.h_gnt, bus.core_stall}, {exp_c, !exp_c, !exp_c});
            end
            if (i > 0) begin
                checks++;
                if ({bus.c_rvalid, bus.h_rvalid} !== {!exp_c, exp_c}) begin
                    errors++;
                    $display("FAIL rr_rvalid[%0d]: got %b%b expected %b%b", i,
                             bus.c_rvalid, bus.h_rvalid, !exp_c, exp_c);
                end
            end
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (bus.h_rvalid !== 1'b1 || bus.h_rdata !== 32'hA500_0083) begin
            errors++;
            $display("FAIL rr_last_rsp: got h_rvalid %b h_rdata %h expected 1 a5000083",
                     bus.h_rvalid, bus.h_rdata);
        end
`ifdef DMEM_ARB_PERF_EN
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++;
            $display("FAIL rr_stall_cnt: got %0d expected 2", stall_cnt);
        end
`endif
    endtask

    task automatic test_host_lock();
        logic [6:0] exp_h;
        exp_h = 7'b1101111;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 9'h050, 32'h0, 1'b1, 1'b0, 1'b1, 9'h060, 32'h0);
            #1;
            checks++;
            if ({bus.c_gnt, bus.h_gnt} !== {!exp_h[i], exp_h[i]}) begin
                errors++;
                $display("FAIL lock_grant[%0d]: got %b%b expected %b%b", i,
                         bus.c_gnt, bus.h_gnt, !exp_h[i], exp_h[i]);
            end
        end
        @(negedge clk);
        idle();
`ifdef DMEM_ARB_PERF_EN
        #1;
        checks++;
        if (stall_cnt !== 32'd6) begin
            errors++;
            $display("FAIL lock_stall_cnt: got %0d expected 6", stall_cnt);
        end
`endif
    endtask

    task automatic test_host_write();
        @(negedge clk);
        drive(1'b0, 1'b0, 9'h0, 32'h0, 1'b1, 1'b1, 1'b0, 9'h1FF, 32'h5A5A5A5A);
        #1;
        checks++;
        if ({bus.c_gnt, bus.h_gnt, bus.mem_rd, bus.mem_wr, bus.core_stall} !== 5'b01010) begin
            errors++;
            $display("FAIL hwrite_strobes: got %b expected 01010",
                     {bus.c_gnt, bus.h_gnt, bus.mem_rd, bus.mem_wr, bus.core_stall});
        end
        checks++;
        if (bus.mem_addr !== 9'h1FF || bus.mem_wr_data !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL hwrite_bus: got addr %h data %h expected 1ff 5a5a5a5a",
                     bus.mem_addr, bus.mem_wr_data);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if ({bus.c_rvalid, bus.h_rvalid, bus.mem_wr, bus.mem_rd} !== 4'b0000 ||
            bus.mem_addr !== 9'h0 || bus.mem_wr_data !== 32'h0) begin
            errors++;
            $display("FAIL hwrite_after: got rv/strb %b addr %h data %h expected 0000 0 0",
                     {bus.c_rvalid, bus.h_rvalid, bus.mem_wr, bus.mem_rd}, bus.mem_addr,
                     bus.mem_wr_data);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        drive(1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
        #1;
        checks++;
        if (bus.c_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_gnt: got %b expected 1", bus.c_gnt);
        end
        @(posedge clk);
        #1;
        idle();
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.c_rvalid, bus.h_rvalid} !== 2'b00 || bus.c_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_async: got rvalid %b%b c_rdata %h expected 00 0",
                     bus.c_rvalid, bus.h_rvalid, bus.c_rdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({bus.c_rvalid, bus.h_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_release: got rvalid %b%b expected 00", bus.c_rvalid, bus.h_rvalid);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 9'h070, 32'h0, 1'b1, 1'b0, 1'b0, 9'h071, 32'h0);
        #1;
        checks++;
        if ({bus.c_gnt, bus.h_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_tie: got %b%b expected 10", bus.c_gnt, bus.h_gnt);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle();
        test_reset();
        test_core_read();
        test_tie_after_reset();
        test_round_robin();
        test_host_lock();
        test_host_write();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
